// File: rtl/lockstep_mode_seq.sv
// Lockstep mode sequencer: drains the cluster, resets shadow cores, releases
// pairs together and compares master/shadow commit signatures while locked.
module lockstep_mode_seq #(
    parameter int N_CORES       = 8,
    parameter int SIG_W         = 32,
    parameter int RST_CYCLES    = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     lockstep_mode_i,
    input  logic [N_CORES-1:0]       core_busy_i,
    input  logic [N_CORES-1:0]       sig_valid_i,
    input  logic [N_CORES*SIG_W-1:0] sig_i,
    input  logic                     err_clr_i,
    output logic [N_CORES-1:0]       fetch_en_o,
    output logic [N_CORES-1:0]       core_rst_o,
    output logic                     lockstep_active_o,
    output logic [N_CORES/2-1:0]     mismatch_o,
    output logic [7:0]               err_cnt_o,
    output logic                     timeout_o
);

    localparam int N_PAIRS = N_CORES / 2;
    localparam int DCNT_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int RCNT_W  = $clog2(RST_CYCLES + 1);

    localparam logic [DCNT_W-1:0]  DRAIN_LAST  = DCNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [RCNT_W-1:0]  RST_LAST    = RCNT_W'(RST_CYCLES - 1);
    localparam logic [N_CORES-1:0] SHADOW_MASK = {N_PAIRS{2'b10}};

    typedef enum logic [1:0] {
        SPLIT,
        DRAIN,
        RESYNC,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic                target_q, target_d;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                timeout_set;
    logic [N_PAIRS-1:0]  pair_miss;
    logic                cmp_en;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        drain_cnt_d = drain_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        timeout_set = 1'b0;

        case (state_q)
            SPLIT: begin
                if (lockstep_mode_i && !timeout_o) begin
                    state_d     = DRAIN;
                    target_d    = 1'b1;
                    drain_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (!lockstep_mode_i) begin
                    state_d     = DRAIN;
                    target_d    = 1'b0;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                // Idle on the final counted cycle still counts as a clean drain.
                if (core_busy_i == '0) begin
                    state_d   = target_q ? RESYNC : SPLIT;
                    rst_cnt_d = '0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = SPLIT;
                    timeout_set = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                end
            end
            RESYNC: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = LOCKED;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCNT_W'(1);
                end
            end
            default: state_d = SPLIT;
        endcase
    end

    // The last LOCKED cycle (mode already dropped) is not compared.
    assign cmp_en = (state_q == LOCKED) && lockstep_mode_i;

    always_comb begin
        pair_miss = '0;
        for (int p = 0; p < N_PAIRS; p++) begin
            if (sig_valid_i[2*p] != sig_valid_i[2*p+1]) begin
                pair_miss[p] = 1'b1;
            end else if (sig_valid_i[2*p] &&
                         (sig_i[2*p*SIG_W +: SIG_W] != sig_i[(2*p+1)*SIG_W +: SIG_W])) begin
                pair_miss[p] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= SPLIT;
            target_q          <= 1'b0;
            drain_cnt_q       <= '0;
            rst_cnt_q         <= '0;
            fetch_en_o        <= {N_CORES{1'b1}};
            core_rst_o        <= '0;
            lockstep_active_o <= 1'b0;
            mismatch_o        <= '0;
            err_cnt_o         <= '0;
            timeout_o         <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            drain_cnt_q <= drain_cnt_d;
            rst_cnt_q   <= rst_cnt_d;

            // Core controls are decoded from the next state so they line up with state_q.
            fetch_en_o        <= (state_d == SPLIT || state_d == LOCKED) ? {N_CORES{1'b1}} : '0;
            core_rst_o        <= (state_d == RESYNC) ? SHADOW_MASK : '0;
            lockstep_active_o <= (state_d == LOCKED);
            mismatch_o        <= cmp_en ? pair_miss : '0;

            if (err_clr_i) begin
                err_cnt_o <= '0;
            end else if (cmp_en && (pair_miss != '0) && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end

            if (err_clr_i) begin
                timeout_o <= 1'b0;
            end else if (timeout_set) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lockstep_mode_seq.sv
// Self-checking bench for lockstep_mode_seq: directed mode transitions plus
// randomized drain lengths and comparator traffic against a behavioural model.
module tb_lockstep_mode_seq;

    localparam int N_CORES = 8;
    localparam int SIG_W   = 32;
    localparam int N_PAIRS = N_CORES / 2;
    localparam int RST_CYC = 4;
    localparam int DRAIN_T = 16;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b0;
    logic                     lockstep_mode_i = 1'b0;
    logic [N_CORES-1:0]       core_busy_i = '0;
    logic [N_CORES-1:0]       sig_valid_i = '0;
    logic [N_CORES*SIG_W-1:0] sig_i = '0;
    logic                     err_clr_i = 1'b0;
    logic [N_CORES-1:0]       fetch_en_o;
    logic [N_CORES-1:0]       core_rst_o;
    logic                     lockstep_active_o;
    logic [N_PAIRS-1:0]       mismatch_o;
    logic [7:0]               err_cnt_o;
    logic                     timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    lockstep_mode_seq #(
        .N_CORES      (N_CORES),
        .SIG_W        (SIG_W),
        .RST_CYCLES   (RST_CYC),
        .DRAIN_TIMEOUT(DRAIN_T)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .lockstep_mode_i  (lockstep_mode_i),
        .core_busy_i      (core_busy_i),
        .sig_valid_i      (sig_valid_i),
        .sig_i            (sig_i),
        .err_clr_i        (err_clr_i),
        .fetch_en_o       (fetch_en_o),
        .core_rst_o       (core_rst_o),
        .lockstep_active_o(lockstep_active_o),
        .mismatch_o       (mismatch_o),
        .err_cnt_o        (err_cnt_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_sig(input int core, input logic [SIG_W-1:0] v);
        sig_i[core*SIG_W +: SIG_W] = v;
    endtask

    // Model of the comparator rules: pair mismatch on valid disagreement or differing signatures.
    function automatic logic [N_PAIRS-1:0] model_miss(input logic [N_CORES-1:0] v,
                                                     input logic [N_CORES*SIG_W-1:0] s);
        logic [N_PAIRS-1:0] m;
        m = '0;
        for (int p = 0; p < N_PAIRS; p++) begin
            if (v[2*p] != v[2*p+1])
                m[p] = 1'b1;
            else if (v[2*p] && s[2*p*SIG_W +: SIG_W] != s[(2*p+1)*SIG_W +: SIG_W])
                m[p] = 1'b1;
        end
        return m;
    endfunction

    // Request lock with cores busy for busy_len cycles, check every cycle until LOCKED, then exit.
    task automatic drain_run(input int busy_len, input logic [N_CORES-1:0] busy_pat);
        int last;
        last = busy_len + 2 + RST_CYC;
        lockstep_mode_i = 1'b1;
        core_busy_i     = busy_pat;
        for (int k = 1; k <= last; k++) begin
            tick();
            check($sformatf("drain%0d_fetch_c%0d", busy_len, k), fetch_en_o,
                  (k == last) ? 8'hFF : 8'h00);
            check($sformatf("drain%0d_rst_c%0d", busy_len, k), core_rst_o,
                  (k >= busy_len + 2 && k <= busy_len + 1 + RST_CYC) ? 8'hAA : 8'h00);
            check($sformatf("drain%0d_active_c%0d", busy_len, k), lockstep_active_o, k == last);
            core_busy_i = (k <= busy_len) ? busy_pat : '0;
        end
        check($sformatf("drain%0d_timeout", busy_len), timeout_o, 1'b0);
        lockstep_mode_i = 1'b0;
        tick();
        check($sformatf("drain%0d_exit_fetch0", busy_len), fetch_en_o, 8'h00);
        tick();
        check($sformatf("drain%0d_exit_fetch1", busy_len), fetch_en_o, 8'hFF);
        check($sformatf("drain%0d_exit_active", busy_len), lockstep_active_o, 1'b0);
    endtask

    initial begin
        int exp_cnt;
        logic [N_PAIRS-1:0] exp_miss;

        // Reset values
        #2 rst_i = 1'b1;
        tick();
        tick();
        check("rst_fetch", fetch_en_o, 8'hFF);
        check("rst_core_rst", core_rst_o, 8'h00);
        check("rst_active", lockstep_active_o, 1'b0);
        check("rst_mismatch", mismatch_o, 4'h0);
        check("rst_err_cnt", err_cnt_o, 8'h00);
        check("rst_timeout", timeout_o, 1'b0);
        rst_i = 1'b0;
        tick();
        check("split_idle_fetch", fetch_en_o, 8'hFF);

        // Clean entry: DRAIN 1, RESYNC 4, LOCKED on cycle 6
        lockstep_mode_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("entry_fetch_c%0d", k), fetch_en_o, (k == 6) ? 8'hFF : 8'h00);
            check($sformatf("entry_rst_c%0d", k), core_rst_o, (k >= 2 && k <= 5) ? 8'hAA : 8'h00);
            check($sformatf("entry_active_c%0d", k), lockstep_active_o, k == 6);
        end

        // Directed mismatches
        set_sig(4, 32'h1234);
        set_sig(5, 32'h1235);
        sig_valid_i = 8'h30;
        tick();
        check("mm45_mismatch", mismatch_o, 4'b0100);
        check("mm45_err_cnt", err_cnt_o, 8'd1);
        sig_valid_i = 8'h00;
        err_clr_i   = 1'b1;
        tick();
        check("mm45_pulse_end", mismatch_o, 4'b0000);
        check("mm_clear", err_cnt_o, 8'd0);
        err_clr_i   = 1'b0;
        sig_valid_i = 8'h70;
        tick();
        check("mm_two_pairs", mismatch_o, 4'b1100);
        check("mm_two_pairs_cnt", err_cnt_o, 8'd1);
        sig_valid_i = 8'h00;
        tick();
        check("mm_two_pairs_end", mismatch_o, 4'b0000);
        check("mm_two_pairs_hold", err_cnt_o, 8'd1);
        exp_cnt = 1;

        // Randomized comparator traffic in LOCKED
        for (int c = 0; c < 200; c++) begin
            for (int p = 0; p < N_PAIRS; p++) begin
                logic [SIG_W-1:0] base;
                int r;
                base = $urandom;
                set_sig(2*p, base);
                set_sig(2*p+1, ($urandom_range(0, 3) == 0) ? base ^ (32'h1 << $urandom_range(0, 31)) : base);
                r = $urandom_range(0, 7);
                sig_valid_i[2*p]   = (r == 0) || (r >= 2 && r <= 4);
                sig_valid_i[2*p+1] = (r == 1) || (r >= 2 && r <= 4);
            end
            err_clr_i = ($urandom_range(0, 15) == 0);
            exp_miss  = model_miss(sig_valid_i, sig_i);
            if (err_clr_i)
                exp_cnt = 0;
            else if (exp_miss != '0 && exp_cnt < 255)
                exp_cnt = exp_cnt + 1;
            tick();
            check($sformatf("rand_mismatch_%0d", c), mismatch_o, exp_miss);
            check($sformatf("rand_err_cnt_%0d", c), err_cnt_o, exp_cnt);
        end
        err_clr_i   = 1'b0;
        sig_valid_i = '0;
        check("rand_still_locked", lockstep_active_o, 1'b1);

        // Saturation over 300 mismatching cycles, then clear during a mismatch
        sig_valid_i = 8'h01;
        for (int c = 0; c < 300; c++) begin
            tick();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end
        check("sat_err_cnt", err_cnt_o, 8'd255);
        check("sat_model", err_cnt_o, exp_cnt);
        check("sat_mismatch", mismatch_o, 4'b0001);
        err_clr_i = 1'b1;
        tick();
        check("clr_wins", err_cnt_o, 8'd0);
        err_clr_i = 1'b0;
        tick();
        check("clr_then_inc", err_cnt_o, 8'd1);

        // Exit: comparator ignored on the exit cycle
        lockstep_mode_i = 1'b0;
        tick();
        check("exit_fetch0", fetch_en_o, 8'h00);
        check("exit_active", lockstep_active_o, 1'b0);
        check("exit_no_mismatch", mismatch_o, 4'b0000);
        check("exit_err_hold", err_cnt_o, 8'd1);
        sig_valid_i = 8'h00;
        tick();
        check("exit_fetch1", fetch_en_o, 8'hFF);

        // Drain waits: directed, success on the last counted cycle, and random lengths
        drain_run(10, 8'h04);
        drain_run(DRAIN_T - 1, 8'h10);
        drain_run(0, 8'h80);
        for (int i = 0; i < 4; i++) begin
            int len;
            len = $urandom_range(0, DRAIN_T - 1);
            drain_run(len, 8'h01 << $urandom_range(0, N_CORES - 1));
        end

        // Drain timeout with a stuck core
        lockstep_mode_i = 1'b1;
        core_busy_i     = 8'h01;
        for (int k = 1; k <= DRAIN_T; k++) begin
            tick();
            check($sformatf("to_fetch_c%0d", k), fetch_en_o, 8'h00);
            check($sformatf("to_flag_c%0d", k), timeout_o, 1'b0);
        end
        tick();
        check("to_flag_set", timeout_o, 1'b1);
        check("to_fetch_split", fetch_en_o, 8'hFF);
        check("to_active", lockstep_active_o, 1'b0);
        core_busy_i = 8'h00;
        for (int k = 0; k < 5; k++) tick();
        check("to_no_retry_fetch", fetch_en_o, 8'hFF);
        check("to_no_retry_flag", timeout_o, 1'b1);
        err_clr_i = 1'b1;
        tick();
        check("to_cleared", timeout_o, 1'b0);
        check("to_clear_cycle_split", fetch_en_o, 8'hFF);
        err_clr_i = 1'b0;
        tick();
        check("to_retry_drain", fetch_en_o, 8'h00);
        for (int k = 0; k < 5; k++) tick();
        check("to_retry_locked", lockstep_active_o, 1'b1);

        // Asynchronous reset in RESYNC
        lockstep_mode_i = 1'b0;
        tick();
        tick();
        lockstep_mode_i = 1'b1;
        tick();
        tick();
        check("arst_in_resync", core_rst_o, 8'hAA);
        #2 rst_i = 1'b1;
        #1;
        check("arst_core_rst", core_rst_o, 8'h00);
        check("arst_fetch", fetch_en_o, 8'hFF);
        check("arst_active", lockstep_active_o, 1'b0);
        lockstep_mode_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        check("arst_after_fetch", fetch_en_o, 8'hFF);
        check("arst_after_err", err_cnt_o, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
